decode_stage: RTL and testbench

Registered RV32I instruction-decode pipeline stage with valid/ready handshakes on both sides, and the successor to the combinational i_decoder. It adds immediate generation, illegal-opcode flagging, a 2-entry skid buffer for full throughput with a registered in_ready, load-use hazard bubble insertion, synchronous flush, and a saturating bubble counter. It sits between instruction fetch and the execute stage.

---
 rtl/decode_stage_pkg.sv | 55 +++++
 rtl/decode_stage_imm_gen.sv | 25 ++
 rtl/decode_stage.sv | 195 +++++++++++++++++++
 tb/tb_decode_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants: ALU operation codes, base opcodes, immediate formats
// and the funct3/funct7 to ALU-operation mapping shared by OP and OP-IMM.
package decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_SLL  = 4'd2,
    ALU_OP_SLT  = 4'd3,
    ALU_OP_SLTU = 4'd4,
    ALU_OP_XOR  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SRA  = 4'd7,
    ALU_OP_OR   = 4'd8,
    ALU_OP_AND  = 4'd9,
    ALU_OP_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // alt is instr[30]; it selects SUB only for register-register ops, SRA for both.
  function automatic alu_op_e funct_alu_op(input logic [2:0] funct3, input logic alt,
                                           input logic is_reg);
    alu_op_e op;
    case (funct3)
      3'd0:    op = (alt && is_reg) ? ALU_OP_SUB : ALU_OP_ADD;
      3'd1:    op = ALU_OP_SLL;
      3'd2:    op = ALU_OP_SLT;
      3'd3:    op = ALU_OP_SLTU;
      3'd4:    op = ALU_OP_XOR;
      3'd5:    op = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'd6:    op = ALU_OP_OR;
      default: op = ALU_OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediate from the instruction, R gives 0.
// Purely combinational; the low 7 opcode bits never contribute so they are not ported in.
module imm_gen
  import decode_stage_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:7] instr,
  input  fmt_e                 fmt,
  output logic [WORD_SIZE-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{(WORD_SIZE-11){instr[31]}}, instr[30:20]};
      FMT_S: imm = {{(WORD_SIZE-11){instr[31]}}, instr[30:25], instr[11:7]};
      FMT_B: imm = {{(WORD_SIZE-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {{(WORD_SIZE-31){instr[31]}}, instr[30:12], 12'b0};
      FMT_J: imm = {{(WORD_SIZE-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one-cycle latency, main + skid entry so in_ready is a flop
// and throughput is 1/cycle; a load-use hazard holds the head for one bubble cycle.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int ADDR_SIZE = 10,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_instr,
  input  logic [ADDR_SIZE-1:0] in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_SIZE-1:0] out_pc,
  output logic [3:0]           alu_op,
  output logic [REG_SEL-1:0]   rs1,
  output logic [REG_SEL-1:0]   rs2,
  output logic [REG_SEL-1:0]   rd,
  output logic [WORD_SIZE-1:0] imm,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src,
  output logic                 branch,
  output logic                 jump,
  output logic                 illegal,
  output logic [CNT_W-1:0]     bubble_count
);

  typedef struct packed {
    logic [ADDR_SIZE-1:0] pc;
    alu_op_e              alu_op;
    logic [REG_SEL-1:0]   rs1;
    logic [REG_SEL-1:0]   rs2;
    logic [REG_SEL-1:0]   rd;
    logic [WORD_SIZE-1:0] imm;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 reg_write;
    logic                 alu_src;
    logic                 branch;
    logic                 jump;
    logic                 illegal;
  } bundle_t;

  logic [6:0]           opc;
  fmt_e                 fmt;
  logic [WORD_SIZE-1:0] dec_imm;
  bundle_t              dec, main_q, skid_q;
  logic                 main_v, skid_v, haz_v;
  logic [REG_SEL-1:0]   haz_rd;
  logic                 stall, accept, drain;

  assign opc = in_instr[6:0];

  always_comb begin
    fmt = FMT_R;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
      OPC_STORE:                      fmt = FMT_S;
      OPC_BRANCH:                     fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
      OPC_JAL:                        fmt = FMT_J;
      default:                        fmt = FMT_R;
    endcase
  end

  imm_gen #(.WORD_SIZE(WORD_SIZE)) u_imm_gen (
    .instr (in_instr[WORD_SIZE-1:7]),
    .fmt   (fmt),
    .imm   (dec_imm)
  );

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.rs1 = REG_SEL'(in_instr[19:15]);
    dec.rs2 = REG_SEL'(in_instr[24:20]);
    dec.rd  = REG_SEL'(in_instr[11:7]);
    dec.imm = dec_imm;
    case (opc)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = funct_alu_op(in_instr[14:12], in_instr[30], 1'b1);
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = funct_alu_op(in_instr[14:12], in_instr[30], 1'b0);
      end
      OPC_LOAD: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OPC_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_OP_SUB;
      end
      OPC_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_OP_LUI;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Unused register fields are zeroed so hazard compares never match stray bits.
    if (fmt == FMT_U || fmt == FMT_J) dec.rs1 = '0;
    if (fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) dec.rs2 = '0;
    if (fmt == FMT_S || fmt == FMT_B) dec.rd = '0;
  end

  // haz_rd is never zero while haz_v is set, so matching a zeroed field cannot stall.
  assign stall     = haz_v && main_v && (main_q.rs1 == haz_rd || main_q.rs2 == haz_rd);
  assign out_valid = main_v && !stall;
  assign in_ready  = !skid_v;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v       <= 1'b0;
      skid_v       <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      haz_v        <= 1'b0;
      haz_rd       <= '0;
      bubble_count <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      haz_v  <= 1'b0;
    end else begin
      if (stall && !(&bubble_count)) bubble_count <= bubble_count + CNT_W'(1);
      haz_v  <= drain && main_q.mem_read && (main_q.rd != '0);
      haz_rd <= main_q.rd;
      if (drain || !main_v) begin
        if (skid_v) begin
          main_v <= 1'b1;
          main_q <= skid_q;
          skid_v <= 1'b0;
        end else begin
          main_v <= accept;
          if (accept) main_q <= dec;
        end
      end else if (accept) begin
        skid_v <= 1'b1;
        skid_q <= dec;
      end
    end
  end

  assign out_pc     = main_q.pc;
  assign alu_op     = main_q.alu_op;
  assign rs1        = main_q.rs1;
  assign rs2        = main_q.rs2;
  assign rd         = main_q.rd;
  assign imm        = main_q.imm;
  assign mem_read   = main_q.mem_read;
  assign mem_write  = main_q.mem_write;
  assign mem_to_reg = main_q.mem_to_reg;
  assign reg_write  = main_q.reg_write;
  assign alu_src    = main_q.alu_src;
  assign branch     = main_q.branch;
  assign jump       = main_q.jump;
  assign illegal    = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed and random stimulus against a queue-based reference
// model of the RV32I decode tables, handshake occupancy, load-use bubbles and flush.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [9:0]  in_pc = '0;
  logic        in_ready, out_valid;
  logic [9:0]  out_pc;
  logic [3:0]  alu_op;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        mem_read, mem_write, mem_to_reg, reg_write, alu_src, branch, jump, illegal;
  logic [15:0] bubble_count;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .alu_op(alu_op),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src(alu_src), .branch(branch), .jump(jump),
    .illegal(illegal), .bubble_count(bubble_count)
  );

  typedef struct packed {
    logic [9:0]  pc;
    logic [3:0]  alu_op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic mem_read, mem_write, mem_to_reg, reg_write, alu_src, branch, jump, illegal;
  } bun_t;

  bun_t        q[$];
  logic        haz_v;
  logic [4:0]  haz_rd;
  logic [15:0] bub;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bun_t dut_b();
    bun_t b;
    b = {out_pc, alu_op, rs1, rs2, rd, imm, mem_read, mem_write, mem_to_reg,
         reg_write, alu_src, branch, jump, illegal};
    return b;
  endfunction

  // Reference decode straight from the RV32I tables, immediates built arithmetically.
  function automatic bun_t model(input logic [31:0] i, input logic [9:0] pc);
    bun_t    b;
    alu_op_e tbl[8];
    logic [31:0] s;
    logic [31:0] ii, ss, bb, uu, jj;
    tbl = '{ALU_OP_ADD, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
            ALU_OP_XOR, ALU_OP_SRL, ALU_OP_OR, ALU_OP_AND};
    s  = i[31] ? 32'hFFFF_FFFF : 32'h0;
    ii = (s & 32'hFFFF_F800) | {21'b0, i[30:20]};
    ss = (s & 32'hFFFF_F800) | ({26'b0, i[30:25]} << 5) | {27'b0, i[11:7]};
    bb = (s & 32'hFFFF_F000) | ({31'b0, i[7]} << 11) | ({26'b0, i[30:25]} << 5)
         | ({28'b0, i[11:8]} << 1);
    uu = i & 32'hFFFF_F000;
    jj = (s & 32'hFFF0_0000) | (i & 32'h000F_F000) | ({31'b0, i[20]} << 11)
         | ({22'b0, i[30:21]} << 1);
    b = '0;
    b.pc = pc; b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.rd = i[11:7];
    case (i[6:0])
      OPC_OP: begin
        b.reg_write = 1;
        b.alu_op = tbl[i[14:12]];
        if (i[30] && i[14:12] == 3'd0) b.alu_op = ALU_OP_SUB;
        if (i[30] && i[14:12] == 3'd5) b.alu_op = ALU_OP_SRA;
      end
      OPC_OP_IMM: begin
        b.reg_write = 1; b.alu_src = 1; b.rs2 = 0; b.imm = ii;
        b.alu_op = tbl[i[14:12]];
        if (i[30] && i[14:12] == 3'd5) b.alu_op = ALU_OP_SRA;
      end
      OPC_LOAD: begin
        b.mem_read = 1; b.mem_to_reg = 1; b.reg_write = 1; b.alu_src = 1;
        b.alu_op = ALU_OP_ADD; b.rs2 = 0; b.imm = ii;
      end
      OPC_STORE: begin
        b.mem_write = 1; b.alu_src = 1; b.alu_op = ALU_OP_ADD; b.rd = 0; b.imm = ss;
      end
      OPC_BRANCH: begin b.branch = 1; b.alu_op = ALU_OP_SUB; b.rd = 0; b.imm = bb; end
      OPC_JAL: begin b.jump = 1; b.reg_write = 1; b.rs1 = 0; b.rs2 = 0; b.imm = jj; end
      OPC_JALR: begin b.jump = 1; b.reg_write = 1; b.alu_src = 1; b.rs2 = 0; b.imm = ii; end
      OPC_LUI: begin
        b.reg_write = 1; b.alu_src = 1; b.alu_op = ALU_OP_LUI; b.rs1 = 0; b.rs2 = 0; b.imm = uu;
      end
      OPC_AUIPC: begin
        b.reg_write = 1; b.alu_src = 1; b.alu_op = ALU_OP_ADD; b.rs1 = 0; b.rs2 = 0; b.imm = uu;
      end
      default: b.illegal = 1;
    endcase
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    haz_v = 0;
    haz_rd = 0;
    bub = 0;
  endtask

  // One clock cycle: drive inputs, compare the cycle's outputs, advance the model.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [9:0] pc,
                     input logic ordy, input logic fl, output logic acc);
    logic stall, exp_ov, exp_ir;
    bun_t popped;
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    stall  = haz_v && q.size() > 0 && (q[0].rs1 == haz_rd || q[0].rs2 == haz_rd);
    exp_ov = q.size() > 0 && !stall;
    exp_ir = q.size() < 2;
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    chk("bubble_count", bubble_count, bub);
    if (exp_ov && out_valid) chk("bundle", dut_b(), q[0]);
    acc = iv && exp_ir && !fl;
    if (fl) begin
      q.delete();
      haz_v = 0;
    end else begin
      if (stall && bub != 16'hFFFF) bub++;
      haz_v = 0;
      if (exp_ov && ordy) begin
        popped = q.pop_front();
        if (popped.mem_read && popped.rd != 0) begin
          haz_v = 1;
          haz_rd = popped.rd;
        end
      end
      if (acc) q.push_back(model(ins, pc));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  ops[11];
    logic [31:0] r;
    ops = '{OPC_LOAD, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, 7'h0B};
    r = $urandom();
    r[6:0]   = ops[$urandom_range(0, 10)];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    logic        acc;
    logic        pend;
    logic [31:0] ins;
    logic [9:0]  pc;
    logic        pat[4];
    int          k, c;

    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_bubble", bubble_count, 16'd0);
    chk("rst_bundle", dut_b(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // add x24,x29,x14
    cyc(1, 32'h00ee8c33, 10'h010, 1, 0, acc);
    chk("add_rd", rd, 5'd24);
    chk("add_rs1", rs1, 5'd29);
    chk("add_rs2", rs2, 5'd14);
    chk("add_alu", alu_op, ALU_OP_ADD);
    chk("add_imm", imm, 32'd0);
    cyc(0, 32'h0, 10'h0, 1, 0, acc);

    // sw x2,8(x1) then beq x0,x0,-4
    cyc(1, 32'h0020a423, 10'h014, 1, 0, acc);
    chk("sw_imm", imm, 32'h0000_0008);
    chk("sw_ctl", {mem_write, alu_src, reg_write, rd}, {1'b1, 1'b1, 1'b0, 5'd0});
    cyc(1, 32'hfe000ee3, 10'h018, 1, 0, acc);
    chk("beq_imm", imm, 32'hFFFF_FFFC);
    chk("beq_ctl", {branch, alu_op}, {1'b1, ALU_OP_SUB});
    cyc(0, 32'h0, 10'h0, 1, 0, acc);

    // Load-use: lw x5 then add x6,x5,x0 -> one bubble; then add x6,x7,x0 -> none
    cyc(1, 32'h0000a283, 10'h020, 1, 0, acc);
    cyc(1, 32'h00028333, 10'h024, 1, 0, acc);
    cyc(0, 32'h0, 10'h0, 1, 0, acc);
    cyc(0, 32'h0, 10'h0, 1, 0, acc);
    chk("bubble_after_use", bubble_count, 16'd1);
    cyc(1, 32'h0000a283, 10'h028, 1, 0, acc);
    cyc(1, 32'h00038333, 10'h02C, 1, 0, acc);
    cyc(0, 32'h0, 10'h0, 1, 0, acc);
    cyc(0, 32'h0, 10'h0, 1, 0, acc);
    chk("bubble_no_use", bubble_count, 16'd1);

    // Stream of 8 with out_ready 1,0,0,1
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    k = 0; c = 0;
    ins = rnd_instr(); pc = 10'h100;
    while (k < 8 && c < 100) begin
      cyc(1, ins, pc, pat[c % 4], 0, acc);
      if (acc) begin k++; ins = rnd_instr(); pc = pc + 10'd4; end
      c++;
    end
    chk("stream_all_accepted", 69'(k), 69'(8));
    repeat (6) cyc(0, 32'h0, 10'h0, 1, 0, acc);

    // Fill main and skid, then flush with a new input present
    cyc(1, 32'h00ee8c33, 10'h200, 0, 0, acc);
    cyc(1, 32'h0020a423, 10'h204, 0, 0, acc);
    cyc(1, 32'h00038333, 10'h208, 0, 1, acc);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    repeat (3) cyc(0, 32'h0, 10'h0, 1, 0, acc);

    // Illegal opcode
    cyc(1, 32'hFFFF_FFFF, 10'h300, 0, 0, acc);
    chk("illegal_flag", illegal, 1'b1);
    chk("illegal_ctl", {mem_read, mem_write, mem_to_reg, reg_write, alu_src, branch, jump}, 7'b0);
    repeat (2) cyc(0, 32'h0, 10'h0, 1, 0, acc);

    // Random traffic with a mid-stream asynchronous reset
    pend = 0; ins = '0; pc = 10'h040;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_bundle", dut_b(), '0);
        chk("arst_bubble", bubble_count, 16'd0);
        model_reset();
        pend = 0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1; ins = rnd_instr(); pc = pc + 10'd4;
      end
      flush = ($urandom_range(0, 24) == 0);
      cyc(pend, ins, pc, ($urandom_range(0, 2) != 0), flush, acc);
      if (acc || flush) pend = 0;
    end
    repeat (4) cyc(0, 32'h0, 10'h0, 1, 0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
